fifo_sync_prog: RTL and testbench
=================================

// Module: fifo_sync_prog
// PURPOSE
//  Parametrised single-clock FIFO that succeeds the basic synchronous FIFO. Adds:
//  - standard or first-word-fall-through (FWFT) read mode
//  - occupancy count and programmable almost-full / almost-empty flags
//  - write-when-full with a simultaneous read, and synchronous flush
//  - overflow / underflow error pulses
//  Sits between producer/consumer blocks on one clock domain; chip-select gated like its predecessor.
// PARAMETERS
//  DATA_WIDTH   32        word width in bits
//  FIFO_DEPTH   8         entries; power of two, >= 2
//  MODE         FIFO_STD  fifo_mode_e: FIFO_STD (registered read) | FIFO_FWFT (head word visible)
//  AF_LVL       6         almost_full when count >= AF_LVL; 1 <= AF_LVL <= FIFO_DEPTH
//  AE_LVL       2         almost_empty when count <= AE_LVL; 0 <= AE_LVL < FIFO_DEPTH
// PORTS
//  clk           in   1               clock, rising edge
//  rst_n         in   1               asynchronous active-low reset
//  cs            in   1               chip select; gates wr_en/rd_en
//  flush         in   1               synchronous clear; not gated by cs
//  wr_en         in   1               write request
//  data_in       in   DATA_WIDTH      write data
//  rd_en         in   1               read (STD) / pop (FWFT) request
//  data_out      out  DATA_WIDTH      read data
//  empty         out  1               no entries
//  full          out  1               FIFO_DEPTH entries
//  almost_empty  out  1               count <= AE_LVL
//  almost_full   out  1               count >= AF_LVL
//  count         out  $clog2(D)+1     occupancy, 0..FIFO_DEPTH
//  overflow      out  1               1-cycle pulse: rejected write
//  underflow     out  1               1-cycle pulse: rejected read
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0
//   - data_out=0, overflow=0, underflow=0
//   - takes effect immediately, including mid-transfer
//  Pointers: log2(D)+1 bits, MSB = wrap bit.
//   - empty = (wr_ptr == rd_ptr)
//   - full  = MSBs differ and lower bits equal
//   - count = wr_ptr - rd_ptr, modulo 2^(log2(D)+1)
//   - wrap-around is natural pointer overflow
//  Accept rules:
//   - rd_fire = cs & rd_en & !empty
//   - wr_fire = cs & wr_en & (!full | rd_fire)
//   - a write while full is accepted only together with an accepted read; count stays D
//   - a read on empty is never accepted; no read-through of the same-cycle write
//  Errors, registered and one cycle wide, the cycle after the attempt:
//   - overflow  = cs & wr_en & !wr_fire
//   - underflow = cs & rd_en & !rd_fire
//   - cs=0: requests ignored, no error pulses
//  flush=1 at a clock edge:
//   - pointers, count and data_out return to reset values
//   - has priority over same-cycle wr/rd; no error pulses
//  FIFO_STD mode:
//   - data_out <= mem[rd_ptr] on rd_fire; valid 1 cycle after rd_en
//   - data_out holds its value otherwise, including on underflow
//  FIFO_FWFT mode:
//   - data_out = mem[rd_ptr] when !empty, else 0
//   - a write into an empty FIFO is visible the cycle after the write edge
//   - rd_fire pops the head; the next word or 0 appears after the edge
//  Flags:
//   - derived combinationally from the registered pointers
//   - all flags update the cycle after the causing edge
// STRUCTURE
//  Package fifo_pkg:
//   - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}
//   - default constants FIFO_DEF_DEPTH=8, FIFO_DEF_WIDTH=32
//  Sub-module fifo_mem_1r1w: DATA_WIDTH x FIFO_DEPTH storage.
//   - synchronous write port, asynchronous read port, no reset on the array
//  Top holds: pointers, accept logic, flags, error pulses, data_out register/mux.
//  Elaboration-time checks on FIFO_DEPTH, AF_LVL and AE_LVL legality.
// TESTING
//  1 STD, D=8:
//    - write 0x11..0x88 -> almost_full=1 at count 6; full=1, count=8 after the 8th
//    - 9th write -> overflow pulse, count stays 8
//  2 Drain with 8 reads -> data_out 0x11..0x88, each 1 cycle after rd_en; empty=1 after the last
//    - extra read -> underflow pulse, data_out holds 0x88
//  3 Full FIFO, wr_en+rd_en with 0x99 -> both accepted, count=8, no overflow
//    - 20 interleaved wr/rd crossing the wrap -> order preserved
//  4 FWFT: write 0xA5 into empty -> next cycle empty=0, data_out=0xA5 with no rd_en
//    - rd_en -> empty=1, data_out=0
//  5 count=5, flush with wr_en=1 same cycle -> count=0, empty=1, almost_empty=1
//    - data dropped, no overflow
//  6 rst_n low mid-burst, between edges -> all outputs at reset values immediately
//    - normal operation on release

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the programmable synchronous FIFO.
// Imported by the interface, storage array and FIFO top.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  localparam int FIFO_DEF_DEPTH = 8;
  localparam int FIFO_DEF_WIDTH = 32;

endpackage

// File: rtl/fifo_sync_prog_if.sv
// Bus bundle for fifo_sync_prog: control, data and status signals.
// master drives cs/flush/wr_en/data_in/rd_en, slave drives data and flags.
interface fifo_sync_prog_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_WIDTH,
  parameter int FIFO_DEPTH = FIFO_DEF_DEPTH
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  cs;
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output cs, flush, wr_en, data_in, rd_en,
    input  data_out, empty, full,
    input  almost_empty, almost_full,
    input  count, overflow, underflow
  );

  modport slave (
    input  cs, flush, wr_en, data_in, rd_en,
    output data_out, empty, full,
    output almost_empty, almost_full,
    output count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_1r1w.sv
// DATA_WIDTH x FIFO_DEPTH storage, synchronous write, async read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module fifo_mem_1r1w
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_WIDTH,
  parameter int FIFO_DEPTH = FIFO_DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(FIFO_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [$clog2(FIFO_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with STD/FWFT read, count, programmable flags.
// Ports: clk, rst_n (async low), bus (fifo_sync_prog_if.slave).
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = FIFO_DEF_WIDTH,
  parameter int         FIFO_DEPTH = FIFO_DEF_DEPTH,
  parameter fifo_mode_e MODE       = FIFO_STD,
  parameter int         AF_LVL     = 6,
  parameter int         AE_LVL     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_sync_prog_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0]   PTR_INC = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] AF_C = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LVL);

  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (AF_LVL < 1 || AF_LVL > FIFO_DEPTH) begin : g_bad_af
    $error("AF_LVL must be in 1..FIFO_DEPTH");
  end
  if (AE_LVL < 0 || AE_LVL >= FIFO_DEPTH) begin : g_bad_ae
    $error("AE_LVL must be in 0..FIFO_DEPTH-1");
  end

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_fire;
  logic                  rd_fire;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign wr_req  = bus.cs & bus.wr_en;
  assign rd_req  = bus.cs & bus.rd_en;
  assign rd_fire = rd_req & ~empty;
  // A full FIFO takes a write only when a read frees the slot.
  assign wr_fire = wr_req & (~full | rd_fire);

  fifo_mem_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire & ~bus.flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_INC;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else if (bus.flush) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.overflow  <= wr_req & ~wr_fire;
      bus.underflow <= rd_req & ~rd_fire;
    end
  end

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          dout_q <= '0;
      else if (bus.flush)  dout_q <= '0;
      else if (rd_fire)    dout_q <= rd_data;
    end
    assign bus.data_out = dout_q;
  end else begin : g_fwft
    assign bus.data_out = empty ? '0 : rd_data;
  end

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AF_C);
  assign bus.almost_empty = (count <= AE_C);

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed self-checking bench for fifo_sync_prog (STD and FWFT).
// Status is packed as {empty,full,ae,af,ovf,unf,count[3:0]}.
module tb_fifo_sync_prog;
  import fifo_pkg::*;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  fifo_sync_prog_if #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) bus_s ();
  fifo_sync_prog_if #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) bus_f ();

  fifo_sync_prog #(
    .DATA_WIDTH(32), .FIFO_DEPTH(8), .MODE(FIFO_STD),
    .AF_LVL(6), .AE_LVL(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  fifo_sync_prog #(
    .DATA_WIDTH(32), .FIFO_DEPTH(8), .MODE(FIFO_FWFT),
    .AF_LVL(6), .AE_LVL(2)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .bus(bus_f)
  );

  logic [9:0] st_s;
  logic [9:0] st_f;
  assign st_s = {bus_s.empty, bus_s.full, bus_s.almost_empty,
                 bus_s.almost_full, bus_s.overflow, bus_s.underflow,
                 bus_s.count};
  assign st_f = {bus_f.empty, bus_f.full, bus_f.almost_empty,
                 bus_f.almost_full, bus_f.overflow, bus_f.underflow,
                 bus_f.count};

  localparam logic [9:0] ST_RST = 10'b1_0_1_0_0_0_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_s.cs = 1'b1; bus_s.flush = 1'b0;
    bus_s.wr_en = 1'b0; bus_s.rd_en = 1'b0;
    bus_s.data_in = '0;
    bus_f.cs = 1'b1; bus_f.flush = 1'b0;
    bus_f.wr_en = 1'b0; bus_f.rd_en = 1'b0;
    bus_f.data_in = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    nvec++;
    if (st_s !== ST_RST) begin
      nerr++;
      $display("FAIL reset std status got=%b exp=%b", st_s, ST_RST);
    end
    nvec++;
    if (bus_s.data_out !== 32'h0) begin
      nerr++;
      $display("FAIL reset std dout got=%h exp=0", bus_s.data_out);
    end
    nvec++;
    if (st_f !== ST_RST || bus_f.data_out !== 32'h0) begin
      nerr++;
      $display("FAIL reset fwft got=%b/%h exp=%b/0",
               st_f, bus_f.data_out, ST_RST);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [9:0] exp;
    for (int i = 0; i < 8; i++) begin
      bus_s.wr_en = 1'b1;
      bus_s.data_in = 32'h11 * (i + 1);
      tick();
      exp = {1'b0, (i + 1) == 8, (i + 1) <= 2, (i + 1) >= 6,
             1'b0, 1'b0, 4'(i + 1)};
      nvec++;
      if (st_s !== exp) begin
        nerr++;
        $display("FAIL fill[%0d] status got=%b exp=%b", i, st_s, exp);
      end
    end
    bus_s.data_in = 32'hEE;
    tick();
    exp = 10'b0_1_0_1_1_0_1000;
    nvec++;
    if (st_s !== exp) begin
      nerr++;
      $display("FAIL overflow status got=%b exp=%b", st_s, exp);
    end
    bus_s.wr_en = 1'b0;
    tick();
    exp = 10'b0_1_0_1_0_0_1000;
    nvec++;
    if (st_s !== exp) begin
      nerr++;
      $display("FAIL overflow end got=%b exp=%b", st_s, exp);
    end
  endtask

  task automatic test_drain();
    logic [9:0]  exp;
    logic [31:0] ed;
    int          n;
    for (int i = 0; i < 8; i++) begin
      bus_s.rd_en = 1'b1;
      tick();
      n  = 7 - i;
      ed = 32'h11 * (i + 1);
      exp = {n == 0, 1'b0, n <= 2, n >= 6, 1'b0, 1'b0, 4'(n)};
      nvec++;
      if (bus_s.data_out !== ed || st_s !== exp) begin
        nerr++;
        $display("FAIL drain[%0d] got=%h/%b exp=%h/%b",
                 i, bus_s.data_out, st_s, ed, exp);
      end
    end
    tick();
    exp = 10'b1_0_1_0_0_1_0000;
    nvec++;
    if (bus_s.data_out !== 32'h88 || st_s !== exp) begin
      nerr++;
      $display("FAIL underflow got=%h/%b exp=88/%b",
               bus_s.data_out, st_s, exp);
    end
    bus_s.rd_en = 1'b0;
    tick();
    nvec++;
    if (st_s !== ST_RST) begin
      nerr++;
      $display("FAIL underflow end got=%b exp=%b", st_s, ST_RST);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] ed;
    logic [9:0]  exp;
    for (int i = 0; i < 8; i++) begin
      bus_s.wr_en = 1'b1;
      bus_s.data_in = 32'h11 * (i + 1);
      q.push_back(32'h11 * (i + 1));
      tick();
    end
    bus_s.rd_en = 1'b1;
    bus_s.data_in = 32'h99;
    q.push_back(32'h99);
    tick();
    ed = q.pop_front();
    exp = 10'b0_1_0_1_0_0_1000;
    nvec++;
    if (bus_s.data_out !== ed || st_s !== exp) begin
      nerr++;
      $display("FAIL full_rw got=%h/%b exp=%h/%b",
               bus_s.data_out, st_s, ed, exp);
    end
    for (int k = 0; k < 20; k++) begin
      bus_s.data_in = 32'hA0 + k;
      q.push_back(32'hA0 + k);
      tick();
      ed = q.pop_front();
      nvec++;
      if (bus_s.data_out !== ed || st_s !== exp) begin
        nerr++;
        $display("FAIL wrap[%0d] got=%h/%b exp=%h/%b",
                 k, bus_s.data_out, st_s, ed, exp);
      end
    end
    bus_s.wr_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      ed = q.pop_front();
      nvec++;
      if (bus_s.data_out !== ed || bus_s.count !== 4'(7 - k)) begin
        nerr++;
        $display("FAIL tail[%0d] got=%h/%0d exp=%h/%0d",
                 k, bus_s.data_out, bus_s.count, ed, 7 - k);
      end
    end
    bus_s.rd_en = 1'b0;
    tick();
  endtask

  task automatic test_fwft();
    logic [9:0] exp;
    nvec++;
    if (bus_f.empty !== 1'b1 || bus_f.data_out !== 32'h0) begin
      nerr++;
      $display("FAIL fwft idle got=%b/%h exp=1/0",
               bus_f.empty, bus_f.data_out);
    end
    bus_f.wr_en = 1'b1;
    bus_f.data_in = 32'hA5;
    tick();
    bus_f.wr_en = 1'b0;
    exp = 10'b0_0_1_0_0_0_0001;
    nvec++;
    if (bus_f.data_out !== 32'hA5 || st_f !== exp) begin
      nerr++;
      $display("FAIL fwft show got=%h/%b exp=a5/%b",
               bus_f.data_out, st_f, exp);
    end
    bus_f.rd_en = 1'b1;
    tick();
    bus_f.rd_en = 1'b0;
    nvec++;
    if (bus_f.data_out !== 32'h0 || st_f !== ST_RST) begin
      nerr++;
      $display("FAIL fwft pop got=%h/%b exp=0/%b",
               bus_f.data_out, st_f, ST_RST);
    end
    bus_f.wr_en = 1'b1;
    bus_f.data_in = 32'h5A;
    tick();
    bus_f.data_in = 32'h3C;
    tick();
    bus_f.wr_en = 1'b0;
    bus_f.rd_en = 1'b1;
    nvec++;
    if (bus_f.data_out !== 32'h5A || bus_f.count !== 4'd2) begin
      nerr++;
      $display("FAIL fwft head got=%h/%0d exp=5a/2",
               bus_f.data_out, bus_f.count);
    end
    tick();
    nvec++;
    if (bus_f.data_out !== 32'h3C || bus_f.count !== 4'd1) begin
      nerr++;
      $display("FAIL fwft next got=%h/%0d exp=3c/1",
               bus_f.data_out, bus_f.count);
    end
    tick();
    tick();
    bus_f.rd_en = 1'b0;
    exp = 10'b1_0_1_0_0_1_0000;
    nvec++;
    if (bus_f.data_out !== 32'h0 || st_f !== exp) begin
      nerr++;
      $display("FAIL fwft underflow got=%h/%b exp=0/%b",
               bus_f.data_out, st_f, exp);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [9:0] exp;
    bus_s.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_s.data_in = 32'hC0 + i;
      tick();
    end
    exp = 10'b0_0_0_0_0_0_0101;
    nvec++;
    if (st_s !== exp) begin
      nerr++;
      $display("FAIL preflush got=%b exp=%b", st_s, exp);
    end
    bus_s.flush = 1'b1;
    bus_s.data_in = 32'hDD;
    tick();
    bus_s.flush = 1'b0;
    bus_s.wr_en = 1'b0;
    nvec++;
    if (st_s !== ST_RST || bus_s.data_out !== 32'h0) begin
      nerr++;
      $display("FAIL flush got=%b/%h exp=%b/0",
               st_s, bus_s.data_out, ST_RST);
    end
    bus_s.rd_en = 1'b1;
    tick();
    bus_s.rd_en = 1'b0;
    exp = 10'b1_0_1_0_0_1_0000;
    nvec++;
    if (st_s !== exp || bus_s.data_out !== 32'h0) begin
      nerr++;
      $display("FAIL flush drop got=%b/%h exp=%b/0",
               st_s, bus_s.data_out, exp);
    end
    tick();
  endtask

  task automatic test_async_reset();
    bus_s.wr_en = 1'b1;
    bus_s.data_in = 32'h31;
    bus_f.wr_en = 1'b1;
    bus_f.data_in = 32'h77;
    tick();
    bus_f.wr_en = 1'b0;
    bus_s.data_in = 32'h32;
    tick();
    bus_s.data_in = 32'h33;
    tick();
    bus_s.rd_en = 1'b1;
    bus_s.data_in = 32'h34;
    tick();
    bus_s.rd_en = 1'b0;
    bus_s.data_in = 32'h35;
    nvec++;
    if (bus_s.data_out !== 32'h31 || bus_f.data_out !== 32'h77) begin
      nerr++;
      $display("FAIL prereset got=%h/%h exp=31/77",
               bus_s.data_out, bus_f.data_out);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (st_s !== ST_RST || bus_s.data_out !== 32'h0) begin
      nerr++;
      $display("FAIL async std got=%b/%h exp=%b/0",
               st_s, bus_s.data_out, ST_RST);
    end
    nvec++;
    if (st_f !== ST_RST || bus_f.data_out !== 32'h0) begin
      nerr++;
      $display("FAIL async fwft got=%b/%h exp=%b/0",
               st_f, bus_f.data_out, ST_RST);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    bus_s.wr_en = 1'b1;
    bus_s.data_in = 32'h42;
    tick();
    bus_s.wr_en = 1'b0;
    bus_s.rd_en = 1'b1;
    tick();
    bus_s.rd_en = 1'b0;
    nvec++;
    if (bus_s.data_out !== 32'h42 || st_s !== ST_RST) begin
      nerr++;
      $display("FAIL post reset got=%h/%b exp=42/%b",
               bus_s.data_out, st_s, ST_RST);
    end
  endtask

  task automatic test_cs_gate();
    bus_s.cs = 1'b0;
    bus_s.wr_en = 1'b1;
    bus_s.rd_en = 1'b1;
    bus_s.data_in = 32'h66;
    tick();
    idle();
    nvec++;
    if (st_s !== ST_RST || bus_s.data_out !== 32'h42) begin
      nerr++;
      $display("FAIL cs gate got=%b/%h exp=%b/42",
               st_s, bus_s.data_out, ST_RST);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_fwft();
    test_flush();
    test_async_reset();
    test_cs_gate();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
